// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared constants, FSM state type and the masked next-index search used by the
// decoder scan sequencer.
package decoder_scan_pkg;

  localparam int NUM_OUT = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } idx_hit_t;

  // Lowest unmasked index at or above lo; lo may be NUM_OUT, meaning "none left".
  function automatic idx_hit_t next_unmasked(input logic [NUM_OUT-1:0] mask,
                                             input logic [SEL_W:0]     lo);
    idx_hit_t hit;
    hit = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if ((i >= int'(lo)) && !mask[i]) begin
        hit.found = 1'b1;
        hit.idx   = SEL_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan master and the decoder scan sequencer.
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  import decoder_scan_pkg::*;

  logic               start;
  logic               stop;
  logic               one_shot;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_OUT-1:0] skip_mask;

  logic [SEL_W-1:0]   sel;
  logic               c;
  logic               b;
  logic               a;
  logic               en416;
  logic               en38_lo;
  logic               en38_hi;
  logic               busy;
  logic               step;
  logic               done;

  modport master (
    output start, stop, one_shot, dwell, skip_mask,
    input  sel, c, b, a, en416, en38_lo, en38_hi, busy, step, done
  );

  modport slave (
    input  start, stop, one_shot, dwell, skip_mask,
    output sel, c, b, a, en416, en38_lo, en38_hi, busy, step, done
  );

endinterface

// File: rtl/decoder_scan_sequencer_timer.sv
// scan_dwell_timer: loadable down-counter; expire_o is high during the last
// cycle of a dwell so the owner can advance and reload on the same edge.
module scan_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = run_i && (count_q == W'(1));

endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: steps an index across a 4:16 / dual 3:8 decoder tree
// with a programmable dwell. Define SKIP_MASK_EN to honour per-index skip bits.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  decoder_scan_sequencer_if.slave   scan_if
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q;
  logic               en38_lo_q;
  logic               en38_hi_q;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_q;
  logic               one_shot_q;

  logic               accept;
  logic               tmr_load;
  logic               tmr_clr;
  logic [DWELL_W-1:0] tmr_val;
  logic               expire;
  logic [DWELL_W-1:0] dwell_in_eff;

  logic [NUM_OUT-1:0] in_mask;
  logic [NUM_OUT-1:0] run_mask;
  idx_hit_t           start_hit;
  idx_hit_t           adv_hit;
  idx_hit_t           wrap_hit;

`ifdef SKIP_MASK_EN
  logic [NUM_OUT-1:0] skip_mask_q;
  assign in_mask  = scan_if.skip_mask;
  assign run_mask = skip_mask_q;
`else
  logic unused_skip_mask;
  assign unused_skip_mask = ^scan_if.skip_mask;
  assign in_mask  = '0;
  assign run_mask = '0;
`endif

  assign dwell_in_eff = (scan_if.dwell == '0) ? DWELL_W'(1) : scan_if.dwell;

  assign start_hit = next_unmasked(in_mask, '0);
  assign adv_hit   = next_unmasked(run_mask, {1'b0, sel_q} + (SEL_W + 1)'(1));
  assign wrap_hit  = next_unmasked(run_mask, '0);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = dwell_q;
    case (state_q)
      IDLE: begin
        if (scan_if.start && !scan_if.stop) begin
          if (start_hit.found) begin
            state_d  = SCAN;
            sel_d    = start_hit.idx;
            accept   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = dwell_in_eff;
          end else begin
            // every index masked: nothing to scan, report an empty pass
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (scan_if.stop) begin
          state_d = IDLE;
          sel_d   = '0;
          tmr_clr = 1'b1;
        end else if (expire) begin
          if (adv_hit.found) begin
            sel_d    = adv_hit.idx;
            step_d   = 1'b1;
            tmr_load = 1'b1;
          end else if (one_shot_q) begin
            state_d = IDLE;
            sel_d   = '0;
            done_d  = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            sel_d    = wrap_hit.idx;
            step_d   = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      en38_lo_q   <= 1'b0;
      en38_hi_q   <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_q     <= '0;
      one_shot_q  <= 1'b0;
`ifdef SKIP_MASK_EN
      skip_mask_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      busy_q    <= (state_d == SCAN);
      en38_lo_q <= (state_d == SCAN) && !sel_d[SEL_W-1];
      en38_hi_q <= (state_d == SCAN) && sel_d[SEL_W-1];
      step_q    <= step_d;
      done_q    <= done_d;
      if (accept) begin
        dwell_q     <= dwell_in_eff;
        one_shot_q  <= scan_if.one_shot;
`ifdef SKIP_MASK_EN
        skip_mask_q <= scan_if.skip_mask;
`endif
      end
    end
  end

  scan_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .run_i      (state_q == SCAN),
    .expire_o   (expire)
  );

  assign scan_if.sel     = sel_q;
  assign scan_if.c       = sel_q[2];
  assign scan_if.b       = sel_q[1];
  assign scan_if.a       = sel_q[0];
  assign scan_if.busy    = busy_q;
  assign scan_if.en416   = busy_q;
  assign scan_if.en38_lo = en38_lo_q;
  assign scan_if.en38_hi = en38_hi_q;
  assign scan_if.step    = step_q;
  assign scan_if.done    = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Randomized self-checking bench for decoder_scan_sequencer against a
// cycle-indexed model of the scan schedule (honours SKIP_MASK_EN when defined).
module tb_decoder_scan_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  decoder_scan_sequencer_if #(.DWELL_W(8)) sif ();

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, en416, en38_lo, en38_hi, sel[3:0], c, b, a, step, done}
  logic [12:0] obs_vec;
  assign obs_vec = {sif.busy, sif.en416, sif.en38_lo, sif.en38_hi, sif.sel,
                    sif.c, sif.b, sif.a, sif.step, sif.done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs t cycles after the accepting edge. The schedule is the list
  // of unmasked indices, each held n cycles; stop at cycle stop_at forces idle.
  function automatic logic [12:0] model_at(input int t, input int n, input bit os,
                                           input logic [15:0] mask, input int stop_at);
    int          seq[$];
    logic [15:0] m;
    logic [3:0]  s;
    int          p;
    bit          stp;
`ifdef SKIP_MASK_EN
    m = mask;
`else
    m = 16'h0000;
`endif
    for (int i = 0; i < 16; i++) if (!m[i]) seq.push_back(i);
    if (stop_at >= 0 && t > stop_at) return 13'd0;
    if (seq.size() == 0) return (t == 0) ? 13'd1 : 13'd0;
    p = t / n;
    if (os && p >= seq.size()) return (t == seq.size() * n) ? 13'd1 : 13'd0;
    s   = 4'(seq[p % seq.size()]);
    stp = (t % n == 0) && (t > 0);
    return {1'b1, 1'b1, ~s[3], s[3], s, s[2], s[1], s[0], stp, 1'b0};
  endfunction

  function automatic bit model_busy(input logic [12:0] v);
    return v[12];
  endfunction

  task automatic test_scan(input string name, input int dw, input bit os,
                           input logic [15:0] mask, input int ncyc,
                           input int stop_at, input bit junk);
    logic [12:0] exp;
    int          n;
    n = (dw == 0) ? 1 : dw;
    sif.dwell     = 8'(dw);
    sif.one_shot  = os;
    sif.skip_mask = mask;
    sif.stop      = 1'b0;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      exp = model_at(t, n, os, mask, stop_at);
      n_total++;
      if (obs_vec !== exp)
        $display("FAIL %s t=%0d got=%b exp=%b", name, t, obs_vec, exp);
      else
        n_pass++;
      sif.stop  = (t == stop_at);
      sif.start = 1'b0;
      if (junk && model_busy(exp)) begin
        sif.start     = 1'($urandom_range(0, 1));
        sif.dwell     = 8'($urandom_range(0, 255));
        sif.one_shot  = 1'($urandom_range(0, 1));
        sif.skip_mask = 16'($urandom);
      end
      tick();
    end
    sif.start = 1'b0;
    sif.stop  = 1'b1;
    tick();
    sif.stop = 1'b0;
    n_total++;
    if (obs_vec !== 13'd0)
      $display("FAIL %s_cleanup got=%b exp=%b", name, obs_vec, 13'd0);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (obs_vec !== 13'd0)
        $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, obs_vec, 13'd0);
      else
        n_pass++;
      tick();
    end
  endtask

  task automatic test_one_shot();
    test_scan("one_shot_dw3", 3, 1'b1, 16'h0000, 51, -1, 1'b1);
  endtask

  task automatic test_continuous();
    test_scan("continuous_dw0", 0, 1'b0, 16'h0000, 40, -1, 1'b1);
  endtask

  task automatic test_stop();
    test_scan("stop_at_sel9", 2, 1'b1, 16'h0000, 24, 18, 1'b0);
  endtask

  task automatic test_start_stop_same();
    sif.dwell    = 8'd1;
    sif.one_shot = 1'b1;
    sif.start    = 1'b1;
    sif.stop     = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs_vec !== 13'd0)
        $display("FAIL start_stop_same cyc=%0d got=%b exp=%b", i, obs_vec, 13'd0);
      else
        n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [12:0] exp;
    sif.dwell     = 8'd2;
    sif.one_shot  = 1'b0;
    sif.skip_mask = 16'h0000;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      exp = model_at(t, 2, 1'b0, 16'h0000, -1);
      n_total++;
      if (obs_vec !== exp)
        $display("FAIL rst_mid_prefix t=%0d got=%b exp=%b", t, obs_vec, exp);
      else
        n_pass++;
      if (t < 10) tick();
    end
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (obs_vec !== 13'd0)
      $display("FAIL rst_mid_async got=%b exp=%b", obs_vec, 13'd0);
    else
      n_pass++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (obs_vec !== 13'd0)
        $display("FAIL rst_mid_idle cyc=%0d got=%b exp=%b", i, obs_vec, 13'd0);
      else
        n_pass++;
    end
    test_scan("restart_after_rst", 1, 1'b1, 16'h0000, 20, -1, 1'b0);
  endtask

  task automatic test_skip_mask();
    test_scan("mask_00F0", 1, 1'b1, 16'h00F0, 16, -1, 1'b1);
    test_scan("mask_FFFF", 2, 1'b1, 16'hFFFF, 4, -1, 1'b0);
    test_scan("mask_cont", 1, 1'b0, 16'h7FFE, 12, -1, 1'b1);
  endtask

  task automatic test_random();
    int          dw;
    bit          os;
    logic [15:0] mask;
    int          ncyc;
    int          stop_at;
    for (int k = 0; k < 8; k++) begin
      dw      = $urandom_range(0, 5);
      os      = 1'($urandom_range(0, 1));
      mask    = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      ncyc    = $urandom_range(20, 90);
      stop_at = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, ncyc - 2);
      test_scan($sformatf("random_%0d", k), dw, os, mask, ncyc, stop_at, 1'b1);
    end
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    sif.start     = 1'b0;
    sif.stop      = 1'b0;
    sif.one_shot  = 1'b0;
    sif.dwell     = 8'd0;
    sif.skip_mask = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_one_shot();
    test_continuous();
    test_stop();
    test_start_stop_same();
    test_reset_mid_scan();
    test_skip_mask();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
